usr_shift_controller: RTL
=========================

USR_SHIFT_CONTROLLER -- requirements
Module: usr_shift_controller

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: tx_valid  input  1  TX requester has a word to serialize.
REQ-004 SHALL have: tx_data  input  4  word to serialize.
REQ-005 SHALL have: tx_ready  output  1  TX word accepted on an edge where tx_valid&tx_ready.
REQ-006 SHALL have: rx_req  input  1  RX requester asks for a 4-bit deserialize.
REQ-007 SHALL have: sin  input  1  serial input bit for RX.
REQ-008 SHALL have: sout  output  1  serial output bit (TX, LSB first).
REQ-009 SHALL have: sout_en  output  1  sout carries a valid bit this cycle.
REQ-010 SHALL have: rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-011 SHALL have: rx_data  output  4  deserialized word.
REQ-012 SHALL have: sel  output  2  current register operation (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-013 SHALL have: q  output  4  internal shared 4-bit shift register contents.
REQ-014 SHALL have: busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL contain one 4-bit universal register q, updated per sel: 00 q<=q; 01 q<={fill,q[3:1]}; 10 q<={q[2:0],fill}; 11 q<=load value; sel 10 is never issued by this block.
REQ-016 SHALL implement FSM states IDLE, SHIFT_TX, SHIFT_RX, RX_DONE with a 2-bit shift counter cnt.
REQ-017 SHALL arbitrate TX vs RX in IDLE only: priority pointer pri (TX after reset); if only one requests it wins; if both, pri wins and pri then toggles to the other requester.
REQ-018 SHALL drive tx_ready = (state==IDLE) & !rst & (!rx_req | pri==TX), combinational, independent of tx_valid.
REQ-019 On TX accept edge: sel=11, q<=tx_data, cnt<=0, state<=SHIFT_TX.
REQ-020 In SHIFT_TX: sout=q[0], sout_en=1, sel=01 with fill 0; cnt increments each edge; after cnt==3 edge, state<=IDLE (exactly 4 bits, cycles N+1..N+4 after accept edge N).
REQ-021 On RX grant edge (IDLE, rx_req, granted): sel=00, cnt<=0, state<=SHIFT_RX.
REQ-022 In SHIFT_RX: sel=01 with fill sin, sampled on each of 4 edges; first sampled bit ends in q[0] (LSB first); after cnt==3 edge, state<=RX_DONE.
REQ-023 In RX_DONE: rx_valid=1 and rx_data=q for exactly one cycle, sel=00; next state IDLE.
REQ-024 rx_data SHALL equal q at all times; consumers use it only when rx_valid=1.
REQ-025 sout and sout_en SHALL be 0 outside SHIFT_TX; rx_valid SHALL be 0 outside RX_DONE.
REQ-026 tx_valid and rx_req SHALL be ignored outside IDLE; a held request is served on return to IDLE (no queueing, no loss while held).
REQ-027 Back-to-back: IDLE lasts at least one cycle between transactions; a new grant may occur on the first IDLE edge.
REQ-028 q SHALL hold (sel=00) in IDLE when no TX accept occurs.

Reset
REQ-029 While rst=1 at an edge: state<=IDLE, q<=0, cnt<=0, pri<=TX; during rst tx_ready=0; sout, sout_en, rx_valid, busy, sel all 0.
REQ-030 Reset mid-transaction SHALL abort it: no further sout bits, no rx_valid pulse, partial data discarded.

Verification
REQ-031 After reset, tx_valid=1, tx_data=1011 -> accept next edge; sout=1,1,0,1 with sout_en=1 over 4 cycles; then q=0000, busy=0.
REQ-032 rx_req=1, sin=1,0,1,1 on 4 successive edges -> rx_valid one cycle, rx_data=1101.
REQ-033 tx_valid and rx_req both held from reset -> TX (1011) served first, then RX, then TX again; tx_ready=0 while rx has priority.
REQ-034 rst asserted during 2nd TX bit -> next cycle sout_en=0, q=0000, busy=0; no residual bits.
REQ-035 rst asserted during RX after 3 bits -> no rx_valid pulse; state IDLE, q=0000.
REQ-036 Two TX words (0110 then 1001) back-to-back with tx_valid held -> 8 bits 0,1,1,0,1,0,0,1 with one idle cycle (sout_en=0) between words.

Source files
------------

// File: rtl/usr_shift_controller.sv
// usr_shift_controller
// Arbitrates a serializer (TX) and a deserializer (RX) that share one 4-bit
// universal shift register. TX words go out LSB first on sout. RX words are
// collected LSB first from sin and presented for one cycle on rx_data/rx_valid.
module usr_shift_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [3:0] tx_data,
    output logic       tx_ready,
    input  logic       rx_req,
    input  logic       sin,
    output logic       sout,
    output logic       sout_en,
    output logic       rx_valid,
    output logic [3:0] rx_data,
    output logic [1:0] sel,
    output logic [3:0] q,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_TX = 2'd1,
        ST_SHIFT_RX = 2'd2,
        ST_RX_DONE  = 2'd3
    } state_t;

    localparam logic       PRI_TX     = 1'b0;
    localparam logic       PRI_RX     = 1'b1;
    localparam logic [1:0] SEL_HOLD   = 2'b00;
    localparam logic [1:0] SEL_SHR    = 2'b01;
    localparam logic [1:0] SEL_SHL    = 2'b10;
    localparam logic [1:0] SEL_LOAD   = 2'b11;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic       pri_r;
    logic       pri_nxt_s;
    logic [3:0] q_r;
    logic [1:0] sel_s;
    logic       fill_s;
    logic       idle_s;
    logic       tx_win_s;
    logic       rx_win_s;

    // Universal register next value for a given operation and fill bit.
    function automatic logic [3:0] usr_next(input logic [3:0] cur,
                                            input logic [1:0] op,
                                            input logic       fill,
                                            input logic [3:0] load);
        logic [3:0] res;
        case (op)
            SEL_HOLD: res = cur;
            SEL_SHR:  res = {fill, cur[3:1]};
            SEL_SHL:  res = {cur[2:0], fill};
            SEL_LOAD: res = load;
            default:  res = cur;
        endcase
        return res;
    endfunction

    assign idle_s = (state_r == ST_IDLE);

    // Grant decision: a lone requester wins; on contention the pointer decides.
    assign tx_win_s = idle_s & tx_valid & (!rx_req   | (pri_r == PRI_TX));
    assign rx_win_s = idle_s & rx_req   & (!tx_valid | (pri_r == PRI_RX));

    // Next-state, counter, pointer and register-operation selection.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pri_nxt_s   = pri_r;
        sel_s       = SEL_HOLD;
        fill_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tx_win_s) begin
                    sel_s       = SEL_LOAD;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = ST_SHIFT_TX;
                    // Pointer only moves when both sides were asking.
                    pri_nxt_s   = rx_req ? PRI_RX : pri_r;
                end else if (rx_win_s) begin
                    sel_s       = SEL_HOLD;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = ST_SHIFT_RX;
                    pri_nxt_s   = tx_valid ? PRI_TX : pri_r;
                end else begin
                    sel_s       = SEL_HOLD;
                end
            end
            ST_SHIFT_TX: begin
                sel_s     = SEL_SHR;
                fill_s    = 1'b0;
                cnt_nxt_s = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT_TX;
                end
            end
            ST_SHIFT_RX: begin
                // Shifting right with sin as fill lands the first bit in q[0].
                sel_s     = SEL_SHR;
                fill_s    = sin;
                cnt_nxt_s = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    state_nxt_s = ST_RX_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT_RX;
                end
            end
            ST_RX_DONE: begin
                sel_s       = SEL_HOLD;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                sel_s       = SEL_HOLD;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, priority pointer and shared shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            pri_r   <= PRI_TX;
            q_r     <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pri_r   <= pri_nxt_s;
            q_r     <= usr_next(q_r, sel_s, fill_s, tx_data);
        end
    end

    // Outputs derive from registered state and are forced quiet while in reset,
    // which also suppresses a partially shifted word on an aborting reset.
    assign tx_ready = idle_s & !rst & (!rx_req | (pri_r == PRI_TX));
    assign sout_en  = (state_r == ST_SHIFT_TX) & !rst;
    assign sout     = (state_r == ST_SHIFT_TX) & !rst & q_r[0];
    assign rx_valid = (state_r == ST_RX_DONE) & !rst;
    assign rx_data  = q_r;
    assign q        = q_r;
    assign busy     = !idle_s & !rst;
    assign sel      = rst ? SEL_HOLD : sel_s;

endmodule
